// File: rtl/mdr_pkg.sv
// mdr_pkg: FSM state and access-size encodings shared by the MDR controller and its lane extender.
package mdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_FULL = 2'b11;

    // Byte offset arrives zero-extended to 3 bits so one check serves both datapath widths.
    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
        return sz == SZ_HALF ? a[0] : sz == SZ_WORD ? |a[1:0] : sz == SZ_FULL ? |a : 1'b0;
    endfunction

endpackage

// File: rtl/mdr_extend.sv
// mdr_extend: selects the addressed lane of a memory word and sign/zero-extends it to DATA_W.
module mdr_extend
    import mdr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             i_data,
    input  logic [1:0]                    i_size,
    input  logic [$clog2(DATA_W/8)-1:0]   i_addr,
    input  logic                          i_sext,
    output logic [DATA_W-1:0]             o_data
);

    logic [DATA_W-1:0] w_sh;
    logic [DATA_W-1:0] w_word;

    assign w_sh = i_data >> {i_addr, 3'b000};

    if (DATA_W > 32) begin : g_wide
        assign w_word = {{(DATA_W-32){i_sext & w_sh[31]}}, w_sh[31:0]};
    end else begin : g_narrow
        assign w_word = w_sh;
    end

    always_comb
        o_data = i_size == SZ_BYTE ? {{(DATA_W-8){i_sext & w_sh[7]}}, w_sh[7:0]}
               : i_size == SZ_HALF ? {{(DATA_W-16){i_sext & w_sh[15]}}, w_sh[15:0]}
               : i_size == SZ_WORD ? w_word
               : w_sh;

endmodule

// File: rtl/mdr_ctrl.sv
// mdr_ctrl: memory data register with sized, aligned memory read/write handshake.
// Define MDR_CTRL_TIMEOUT_EN to abandon a transaction after TIMEOUT_CYC cycles without mem_ack.
module mdr_ctrl
    import mdr_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          clear_n,
    input  logic [DATA_W-1:0]             bus_mux_out,
    input  logic                          MDRin,
    input  logic                          Read,
    input  logic                          Write,
    input  logic [1:0]                    size,
    input  logic                          sign_ext,
    input  logic [$clog2(DATA_W/8)-1:0]   addr_lo,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [DATA_W/8-1:0]           mem_be,
    output logic [DATA_W-1:0]             mdr_out,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(NB);

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_mdr, r_wdata, w_wdata, w_ext;
    logic [NB-1:0]     r_be, w_be, w_mask;
    logic [1:0]        r_size;
    logic [AW-1:0]     r_addr;
    logic              r_sext, r_done, r_err;
    logic              w_idle, w_misal, w_rd, w_wr, w_bad, w_ack, w_tmo;

    assign w_idle  = r_state == ST_IDLE;
    assign w_misal = misaligned(size, 3'(addr_lo));
    assign w_rd    = w_idle && Read && !w_misal;
    assign w_wr    = w_idle && !Read && Write && !w_misal;
    assign w_bad   = w_idle && (Read || Write) && w_misal;
    assign w_ack   = !w_idle && mem_ack;

`ifdef MDR_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;

    // r_cnt holds the number of ack-less wait cycles already completed.
    always_ff @(posedge clk or negedge clear_n)
        if (!clear_n)
            r_cnt <= '0;
        else if (w_rd || w_wr)
            r_cnt <= '0;
        else if (!w_idle)
            r_cnt <= r_cnt + 1'b1;

    assign w_tmo = !w_idle && !mem_ack && r_cnt == CW'(TIMEOUT_CYC - 1);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge clear_n)
        if (!clear_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (w_rd)
            w_next = ST_RD_WAIT;
        else if (w_wr)
            w_next = ST_WR_WAIT;
        else if (w_ack || w_tmo)
            w_next = ST_IDLE;
    end

    always_comb begin
        mem_req = !w_idle;
        mem_we  = r_state == ST_WR_WAIT;
        busy    = !w_idle;
    end

    always_comb begin
        w_wdata = size == SZ_BYTE ? {NB{r_mdr[7:0]}}
                : size == SZ_HALF ? {(NB/2){r_mdr[15:0]}}
                : size == SZ_WORD ? {(DATA_W/32){r_mdr[31:0]}}
                : r_mdr;
        w_mask  = size == SZ_BYTE ? NB'(1) : size == SZ_HALF ? NB'(3) : size == SZ_WORD ? NB'(15) : '1;
        w_be    = w_mask << addr_lo;
    end

    mdr_extend #(.DATA_W(DATA_W)) u_extend (
        .i_data (mem_rdata),
        .i_size (r_size),
        .i_addr (r_addr),
        .i_sext (r_sext),
        .o_data (w_ext)
    );

    // Access attributes are captured at request so the bus may move on while waiting.
    always_ff @(posedge clk or negedge clear_n)
        if (!clear_n) begin
            r_mdr   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_size  <= SZ_BYTE;
            r_addr  <= '0;
            r_sext  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_ack;
            r_err  <= w_bad || w_tmo;
            if (w_rd || w_wr) begin
                r_size <= size;
                r_addr <= addr_lo;
                r_sext <= sign_ext;
            end
            if (w_wr) begin
                r_wdata <= w_wdata;
                r_be    <= w_be;
            end
            if (w_ack && r_state == ST_RD_WAIT)
                r_mdr <= w_ext;
            else if (w_idle && MDRin && !Read && !Write)
                r_mdr <= bus_mux_out;
        end

    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign mdr_out   = r_mdr;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mdr_ctrl.sv
// tb_mdr_ctrl: directed-vector bench for mdr_ctrl at DATA_W=32 with hand-computed expectations.
module tb_mdr_ctrl;

    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic [DW-1:0] bus_mux_out = '0;
    logic          MDRin = 1'b0, Read = 1'b0, Write = 1'b0, sign_ext = 1'b0, mem_ack = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [1:0]    addr_lo = 2'd0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_req, mem_we, busy, done, err;
    logic [DW-1:0] mem_wdata, mdr_out;
    logic [3:0]    mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    mdr_ctrl #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .clear_n(clear_n), .bus_mux_out(bus_mux_out), .MDRin(MDRin),
        .Read(Read), .Write(Write), .size(size), .sign_ext(sign_ext), .addr_lo(addr_lo),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mdr_out(mdr_out), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        #12;
        chk("rst_mdr", mdr_out, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_wdata", mem_wdata, 0);
        clear_n = 1'b1;
        tick();

        // bus load
        MDRin = 1; bus_mux_out = 32'hDEADBEEF;
        tick();
        MDRin = 0;
        chk("load_mdr", mdr_out, 32'hDEADBEEF);
        chk("load_busy", busy, 0);

        // signed byte read, ack after 3 cycles, MDRin ignored while waiting
        Read = 1; size = 2'b00; sign_ext = 1; addr_lo = 2; mem_rdata = 32'h12F45678;
        tick();
        Read = 0; MDRin = 1; bus_mux_out = 32'h11111111;
        chk("rd_req", mem_req, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_busy", busy, 1);
        tick();
        tick();
        chk("rd_hold_mdr", mdr_out, 32'hDEADBEEF);
        chk("rd_no_done", done, 0);
        MDRin = 0; mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("rd_done", done, 1);
        chk("rd_mdr", mdr_out, 32'hFFFFFFF4);
        chk("rd_idle", busy, 0);
        tick();
        chk("rd_done_pulse", done, 0);

        // half write with lane replication
        MDRin = 1; bus_mux_out = 32'h0000ABCD;
        tick();
        MDRin = 0; Write = 1; size = 2'b01; addr_lo = 2;
        tick();
        Write = 0; size = 2'b00; addr_lo = 1;
        chk("wr_wdata", mem_wdata, 32'hABCDABCD);
        chk("wr_be", mem_be, 4'b1100);
        chk("wr_we", mem_we, 1);
        tick();
        chk("wr_wdata_hold", mem_wdata, 32'hABCDABCD);
        chk("wr_be_hold", mem_be, 4'b1100);
        chk("wr_we_hold", mem_we, 1);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("wr_done", done, 1);
        chk("wr_req_drop", mem_req, 0);
        chk("wr_mdr_same", mdr_out, 32'h0000ABCD);

        // misaligned word read
        Read = 1; size = 2'b10; addr_lo = 1;
        tick();
        Read = 0;
        chk("mis_err", err, 1);
        chk("mis_req", mem_req, 0);
        chk("mis_busy", busy, 0);
        tick();
        chk("mis_err_pulse", err, 0);

        // misaligned half write
        Write = 1; size = 2'b01; addr_lo = 3;
        tick();
        Write = 0;
        chk("mis_wr_err", err, 1);
        chk("mis_wr_req", mem_req, 0);

        // priority: read wins over write and MDRin
        Read = 1; Write = 1; MDRin = 1; size = 2'b10; addr_lo = 0; sign_ext = 0;
        bus_mux_out = 32'h55555555; mem_rdata = 32'hCAFEF00D;
        tick();
        Read = 0; Write = 0; MDRin = 0;
        chk("pri_req", mem_req, 1);
        chk("pri_we", mem_we, 0);
        chk("pri_mdr", mdr_out, 32'h0000ABCD);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("pri_done", done, 1);
        chk("pri_mdr_rd", mdr_out, 32'hCAFEF00D);

        // minimum-latency zero-extended half read
        Read = 1; size = 2'b01; addr_lo = 2; sign_ext = 0; mem_rdata = 32'h87654321;
        tick();
        Read = 0; mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("half_done", done, 1);
        chk("half_mdr", mdr_out, 32'h00008765);

        // ack while idle is ignored
        tick();
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("idle_ack_done", done, 0);
        chk("idle_ack_busy", busy, 0);

        // byte write replication at offset 3
        MDRin = 1; bus_mux_out = 32'h123456A5;
        tick();
        MDRin = 0; Write = 1; size = 2'b00; addr_lo = 3;
        tick();
        Write = 0;
        chk("bw_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("bw_be", mem_be, 4'b1000);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("bw_done", done, 1);

        // reset in WR_WAIT
        Write = 1; size = 2'b10; addr_lo = 0;
        tick();
        Write = 0;
        chk("rw_req", mem_req, 1);
        clear_n = 0;
        #1;
        chk("rw_req_async", mem_req, 0);
        chk("rw_mdr_async", mdr_out, 0);
        chk("rw_be_async", mem_be, 0);
        tick();
        #3;
        clear_n = 1;
        mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("rw_no_done", done, 0);
        chk("rw_busy", busy, 0);

        // wait without ack
        MDRin = 1; bus_mux_out = 32'h0BADF00D;
        tick();
        MDRin = 0; Read = 1; size = 2'b10; addr_lo = 0;
        tick();
        Read = 0;
        seen = 0;
        for (int i = 1; i <= TMO + 8; i++) begin
            tick();
            if (err && seen == 0) seen = i;
        end
`ifdef MDR_CTRL_TIMEOUT_EN
        chk("tmo_cycle", seen, TMO);
        chk("tmo_busy", busy, 0);
        chk("tmo_done", done, 0);
        chk("tmo_mdr", mdr_out, 32'h0BADF00D);
`else
        chk("wait_no_err", seen, 0);
        chk("wait_busy", busy, 1);
        mem_rdata = 32'h00000080; size = 2'b00; mem_ack = 1;
        tick();
        mem_ack = 0;
        chk("wait_done", done, 1);
        chk("wait_mdr", mdr_out, 32'h00000080);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdr_ctrl.md
MDR_CTRL -- requirements
Module: mdr_ctrl

Interface
REQ-001 Parameter DATA_W, default 32; datapath width; legal values 32 or 64.
REQ-002 Parameter TIMEOUT_CYC, default 16; maximum number of mem_ack wait cycles (used only under REQ-031).
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 clear_n  in  1  reset; asynchronous, active-low.
REQ-005 bus_mux_out  in  DATA_W  internal bus value; the source for MDRin loads.
REQ-006 MDRin  in  1  load mdr_out from bus_mux_out.
REQ-007 Read, Write  in  1 each  start a memory read or memory write.
REQ-008 size  in  2  access size: 00 byte, 01 half, 10 word(32), 11 full DATA_W (equals word when DATA_W=32).
REQ-009 sign_ext  in  1  on reads, 1 sign-extends and 0 zero-extends sub-width data.
REQ-010 addr_lo  in  log2(DATA_W/8)  byte offset within the memory word.
REQ-011 mem_rdata  in  DATA_W  memory read data.
REQ-012 mem_ack  in  1  memory completion strobe.
REQ-013 mem_req, mem_we  out  1 each  memory request and write qualifier.
REQ-014 mem_wdata  out  DATA_W  write data; mem_be  out  DATA_W/8  byte enables.
REQ-015 mdr_out  out  DATA_W  register contents.
REQ-016 busy, done, err  out  1 each  transaction status.

Function
REQ-017 FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE SHALL return to IDLE from either WAIT state on the edge mem_ack is sampled high.
REQ-018 In IDLE, MDRin, Read and Write SHALL be resolved by priority Read > Write > MDRin; only the highest-priority request present is acted on.
REQ-019 Read in IDLE SHALL go to RD_WAIT.
- mem_req=1 and mem_we=0 from the next cycle until ack.
REQ-020 Write in IDLE SHALL go to WR_WAIT.
- mem_req=1 and mem_we=1.
- mem_wdata and mem_be stay stable until ack.
REQ-021 Write data: the low size-width bits of mdr_out SHALL be replicated across all lanes of mem_wdata.
- mem_be = contiguous size-width mask shifted by addr_lo.
REQ-022 On ack in RD_WAIT, mdr_out SHALL load the lane selected by addr_lo/size from mem_rdata, extended to DATA_W per sign_ext.
REQ-023 done SHALL pulse high for exactly one cycle, in the cycle after ack is sampled; minimum read/write latency is 2 cycles from Read/Write to done.
REQ-024 busy SHALL equal (state != IDLE).
- MDRin, Read and Write are ignored while busy=1.
REQ-025 mem_ack sampled in IDLE SHALL be ignored.
REQ-026 Misalignment SHALL cause no request, no state change and a one-cycle err pulse; mdr_out is unchanged.
- Misaligned means: half with addr_lo[0]=1, word with addr_lo[1:0]!=0, or full with addr_lo!=0.
REQ-027 err SHALL otherwise be 0 except as in REQ-031.

Reset
REQ-028 When clear_n=0, immediately: state=IDLE, and mdr_out, mem_req, mem_we, mem_wdata, mem_be, busy, done and err are all 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no done pulse.
- A mem_ack arriving after reset is released is ignored (REQ-025).

Configuration
REQ-030 Macro MDR_CTRL_TIMEOUT_EN SHALL control a wait-cycle counter in RD_WAIT and WR_WAIT.
REQ-031 With MDR_CTRL_TIMEOUT_EN defined: after TIMEOUT_CYC cycles without ack, the block SHALL drop mem_req, return to IDLE and pulse err for one cycle (no done).
- mdr_out is unchanged.
REQ-032 With MDR_CTRL_TIMEOUT_EN not defined: no counter exists; the block waits for ack indefinitely and TIMEOUT_CYC is unused.

Structure
REQ-033 Package mdr_pkg SHALL hold the FSM state enum and the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_FULL).
REQ-034 Sub-module mdr_extend SHALL perform the combinational lane selection and sign/zero extension used by REQ-022.

Verification
REQ-035 Bus load: MDRin=1, bus_mux_out=0xDEADBEEF -> mdr_out=0xDEADBEEF next cycle; busy stays 0.
REQ-036 Byte signed read:
- Stimulus: Read, size=00, sign_ext=1, addr_lo=2, mem_rdata=0x12F45678, ack after 3 cycles.
- Response: mdr_out=0xFFFFFFF4; done pulses one cycle after ack.
REQ-037 Half write:
- Stimulus: mdr_out=0x0000ABCD, Write, size=01, addr_lo=2.
- Response: mem_wdata=0xABCDABCD, mem_be=4'b1100, mem_we=1 held until ack.
REQ-038 Misaligned read: Read, size=10, addr_lo=1 -> err pulse, mem_req stays 0, busy stays 0.
REQ-039 Priority and ignore:
- Read+Write+MDRin in the same cycle -> read only.
- MDRin during RD_WAIT -> mdr_out unchanged until ack.
REQ-040 Reset in WR_WAIT: clear_n low for 1 cycle -> mem_req=0 immediately, no done; a later ack is ignored.
- With MDR_CTRL_TIMEOUT_EN defined and no ack: err pulses TIMEOUT_CYC cycles after mem_req rises.
